// File: rtl/regfile_reader.sv
// Burst reader: streams consecutive register file entries out
// through a single registered valid/ready output stage.
module regfile_reader #(
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic          abort,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [AW:0]   DMAX  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ALAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW:0]   rem;
  logic          free;

  assign free    = !m_valid || m_ready;
  assign rf_addr = addr;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      rem     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort wins over any handshake and suppresses done
      if (busy && abort) begin
        state   <= IDLE;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              addr  <= base;
              rem   <= (len > DMAX) ? DMAX : len;
              state <= (len == '0) ? DRAIN : RUN;
            end
          end
          RUN: begin
            if (free) begin
              m_data  <= rf_rdata;
              m_valid <= 1'b1;
              m_last  <= (rem == (AW+1)'(1));
              addr    <= (addr == ALAST) ? '0 : addr + AW'(1);
              rem     <= rem - (AW+1)'(1);
              if (rem == (AW+1)'(1)) begin
                state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (free) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: directed table,
// multi-cycle corner sequences and a randomized scoreboard.
module tb_regfile_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          abort;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rf_rdata = mem[rf_addr];

  regfile_reader #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .len     (len),
    .abort   (abort),
    .rf_addr (rf_addr),
    .rf_rdata(rf_rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    string         name;
    logic [AW-1:0] b;
    logic [AW:0]   l;
    int            mode;
    bit            poke;
    int            n;
    logic [7:0]    fd;
    logic [7:0]    ld;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random
  task automatic run_burst(input logic [AW-1:0] b,
                           input logic [AW:0] l,
                           input int mode, input bit poke,
                           output int cnt,
                           output logic [7:0] fd,
                           output logic [7:0] ld);
    logic [8:0] exp_q [$];
    logic [8:0] e;
    int n, popped;
    bit got_last, pv, pr, pl;
    logic [7:0] pd;
    n = (int'(l) > DEPTH) ? DEPTH : int'(l);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), mem[(int'(b) + i) % DEPTH]});
    cnt = 0; fd = '0; ld = '0;
    popped = 0; got_last = 0;
    pv = 0; pr = 0; pd = '0; pl = 0;
    start = 1'b1; base = b; len = l;
    tick();
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("latency_rfaddr", rf_addr, b);
    chk("latency_valid0", m_valid, 0);
    if (n == 0) begin
      tick();
      chk("zero_done", done, 1);
      chk("zero_valid", m_valid, 0);
      chk("zero_idle", busy, 0);
      tick();
      chk("zero_done_pulse", done, 0);
      return;
    end
    for (int c = 1; c <= 4 * n + 20 && !got_last; c++) begin
      tick();
      if (poke && c == 2) begin
        start = 1'b1; base = b + 8'd77; len = 9'd1;
      end else begin
        start = 1'b0;
      end
      if (c == 1) chk("first_beat_valid", m_valid, 1);
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (c % 3 == 1);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      chk("done_low", done, 0);
      chk("rf_addr",
          rf_addr, (int'(b) + popped + int'(m_valid)) % DEPTH);
      if (pv && !pr) begin
        chk("stall_data", m_data, pd);
        chk("stall_last", m_last, pl);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e[7:0]);
          chk("beat_last", m_last, e[8]);
          if (cnt == 0) fd = m_data;
          ld = m_data;
          cnt++;
          popped++;
          if (e[8]) got_last = 1;
        end
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
    end
    start = 1'b0;
    if (!got_last) begin
      chk("timeout", 0, 1);
    end else begin
      tick();
      chk("done_high", done, 1);
      chk("drained_valid", m_valid, 0);
      chk("drained_last", m_last, 0);
      chk("idle", busy, 0);
      tick();
      chk("done_single", done, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [8];
    int cnt, n;
    logic [7:0] fd, ld;
    logic [AW-1:0] rb;
    logic [AW:0] rl;

    vt[0] = '{"basic", 8'd4, 9'd3, 0, 0, 3, 8'h14, 8'h16};
    vt[1] = '{"wrap", 8'd254, 9'd4, 0, 0, 4, 8'h0E, 8'h11};
    vt[2] = '{"backpr", 8'd10, 9'd6, 1, 0, 6, 8'h1A, 8'h1F};
    vt[3] = '{"zero", 8'd0, 9'd0, 0, 0, 0, 8'h00, 8'h00};
    vt[4] = '{"over", 8'd7, 9'd300, 0, 0, 256, 8'h17, 8'h16};
    vt[5] = '{"poke", 8'd20, 9'd5, 0, 1, 5, 8'h24, 8'h28};
    vt[6] = '{"rndrdy", 8'd100, 9'd10, 2, 0, 10, 8'h74, 8'h7D};
    vt[7] = '{"full", 8'd0, 9'd256, 1, 0, 256, 8'h10, 8'h0F};

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 16);

    rst = 1'b1; start = 1'b1; abort = 1'b1;
    m_ready = 1'b0; base = 8'd9; len = 9'd3;
    tick();
    tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", rf_addr, 0);
    rst = 1'b0; start = 1'b0; abort = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_burst(vt[i].b, vt[i].l, vt[i].mode, vt[i].poke,
                cnt, fd, ld);
      chk({vt[i].name, "_count"}, cnt, vt[i].n);
      if (vt[i].n > 0) begin
        chk({vt[i].name, "_first"}, fd, vt[i].fd);
        chk({vt[i].name, "_lastd"}, ld, vt[i].ld);
      end
    end

    start = 1'b1; base = 8'd30; len = 9'd5;
    tick();
    start = 1'b0; m_ready = 1'b1;
    tick();
    tick();
    chk("abort_beat2", m_data, mem[31]);
    m_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", m_valid, 0);
    chk("abort_last", m_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_nodone", done, 0);
    run_burst(8'd40, 9'd2, 0, 0, cnt, fd, ld);
    chk("after_abort_count", cnt, 2);

    start = 1'b1; base = 8'd50; len = 9'd1;
    tick();
    start = 1'b0;
    tick();
    chk("drain_valid", m_valid, 1);
    m_ready = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_prio_done", done, 0);
    chk("abort_prio_busy", busy, 0);
    chk("abort_prio_valid", m_valid, 0);
    tick();
    chk("abort_prio_nodone", done, 0);

    start = 1'b1; abort = 1'b1; base = 8'd5; len = 9'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_start_busy", busy, 0);
    chk("idle_abort_start_valid", m_valid, 0);

    m_ready = 1'b1;
    start = 1'b1; base = 8'd60; len = 9'd8;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_data", m_data, mem[62]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_last", m_last, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", rf_addr, 0);
    run_burst(8'd3, 9'd4, 0, 0, cnt, fd, ld);
    chk("post_rst_count", cnt, 4);

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 25; k++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0)
        rl = 9'($urandom_range(0, 300));
      else
        rl = 9'($urandom_range(0, 12));
      n = (int'(rl) > DEPTH) ? DEPTH : int'(rl);
      run_burst(rb, rl, 2, 1'($urandom_range(0, 1)), cnt, fd, ld);
      chk("rand_count", cnt, n);
      if (n > 0) begin
        chk("rand_first", fd, mem[rb]);
        chk("rand_lastd", ld, mem[(int'(rb) + n - 1) % DEPTH]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
